// File: rtl/ram_master.sv
// ram_master: single-outstanding burst initiator for the ram slave bus.
// The host stages data in an 8-word line buffer; each request is one burst.
module ram_master #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int LWIDTH = 8,
  parameter int MAXLEN = 8,
  parameter int IWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [LWIDTH-1:0] req_len,
  input  logic              buf_we,
  input  logic [IWIDTH-1:0] buf_idx,
  input  logic [DWIDTH-1:0] buf_wdata,
  output logic [DWIDTH-1:0] buf_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AWIDTH-1:0] awaddr,
  output logic [LWIDTH-1:0] awlen,
  output logic              awvalid,
  input  logic              awready,
  output logic [DWIDTH-1:0] wdata,
  output logic              wready,
  input  logic              wvalid,
  input  logic              wlast,
  output logic [AWIDTH-1:0] araddr,
  output logic [LWIDTH-1:0] arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DWIDTH-1:0] rdata,
  output logic              rready,
  input  logic              rvalid,
  input  logic              rlast
);

  typedef enum logic [2:0] {
    IDLE, AW, WDATA, WGAP, AR, RDATA
  } state_t;

  localparam logic [LWIDTH-1:0] LEN_MAX =
    LWIDTH'(MAXLEN);

  state_t              state_q;
  logic [AWIDTH-1:0]   awaddr_q;
  logic [LWIDTH-1:0]   awlen_q;
  logic                awvalid_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                wready_q;
  logic [AWIDTH-1:0]   araddr_q;
  logic [LWIDTH-1:0]   arlen_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                done_q;
  logic                err_q;
  logic [LWIDTH-1:0]   beat_q;
  logic [LWIDTH-1:0]   beat_d;
  logic [DWIDTH-1:0]   buf_q [MAXLEN];

  logic unused_in;
  assign unused_in = ^{wvalid, wlast, rvalid, rlast};

  assign beat_d = beat_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wready_q  <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      beat_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_len == '0) begin
              done_q <= 1'b1;
            end else if (req_len > LEN_MAX) begin
              err_q <= 1'b1;
            end else if (req_write) begin
              awaddr_q  <= req_addr;
              awlen_q   <= req_len;
              awvalid_q <= 1'b1;
              state_q   <= AW;
            end else begin
              araddr_q  <= req_addr;
              arlen_q   <= req_len;
              arvalid_q <= 1'b1;
              state_q   <= AR;
            end
          end
        end
        AW: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            wready_q  <= 1'b1;
            wdata_q   <= buf_q[0];
            beat_q    <= '0;
            state_q   <= WDATA;
          end
        end
        WDATA: begin
          beat_q <= beat_d;
          if (beat_q == awlen_q - 1'b1) begin
            wready_q <= 1'b0;
            wdata_q  <= '0;
            state_q  <= WGAP;
          end else begin
            wdata_q <= buf_q[IWIDTH'(beat_d)];
          end
        end
        // Lets the slave drain its terminal-check cycle.
        WGAP: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= RDATA;
          end
        end
        RDATA: begin
          beat_q   <= beat_d;
          rready_q <= (beat_d < arlen_q);
          if (beat_q == arlen_q) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // rdata lags rready by one cycle, so beat k lands in buf[k-1].
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == IDLE && buf_we) begin
        buf_q[buf_idx] <= buf_wdata;
      end else if (state_q == RDATA &&
                   beat_q != '0) begin
        buf_q[IWIDTH'(beat_q - 1'b1)] <= rdata;
      end
    end
  end

  rlast_on_final_capture: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == RDATA && beat_q == arlen_q)
      |-> rlast
  );

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign awaddr    = awaddr_q;
  assign awlen     = awlen_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wready    = wready_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign buf_rdata = buf_q[buf_idx];

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: directed bench for ram_master with a small ram slave
// model and a queue-based scoreboard for beats and completions.
module tb_ram_master;

  localparam int IW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic        buf_we = 1'b0;
  logic [2:0]  buf_idx = '0;
  logic [31:0] buf_wdata = '0;
  logic [31:0] buf_rdata;
  logic        busy, done, err;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready;
  logic        wready, wvalid, wlast;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rready, rvalid, rlast;

  always #5 clk = ~clk;

  ram_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len),
    .buf_we(buf_we), .buf_idx(buf_idx),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .busy(busy), .done(done), .err(err),
    .awaddr(awaddr), .awlen(awlen),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wready(wready),
    .wvalid(wvalid), .wlast(wlast),
    .araddr(araddr), .arlen(arlen),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rready(rready),
    .rvalid(rvalid), .rlast(rlast)
  );

  // Slave model: ready only when idle, one check cycle after writes.
  typedef enum logic [1:0] {
    S_IDLE, S_W, S_WCHK, S_R
  } s_t;
  s_t          s_st;
  logic [31:0] mem [64];
  logic [31:0] s_addr;
  logic [7:0]  s_len, s_cnt;

  assign awready = (s_st == S_IDLE);
  assign arready = (s_st == S_IDLE);
  assign wvalid  = (s_st == S_W);
  assign wlast   = 1'b0;

  initial for (int i = 0; i < 64; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      s_st   <= S_IDLE;
      rdata  <= '0;
      rlast  <= 1'b0;
      rvalid <= 1'b0;
      s_cnt  <= '0;
    end else begin
      rlast  <= 1'b0;
      rvalid <= 1'b0;
      case (s_st)
        S_IDLE: begin
          if (awvalid) begin
            s_st   <= S_W;
            s_addr <= awaddr >> 2;
            s_len  <= awlen;
            s_cnt  <= '0;
          end else if (arvalid) begin
            s_st   <= S_R;
            s_addr <= araddr >> 2;
            s_len  <= arlen;
            s_cnt  <= '0;
          end
        end
        S_W: if (wready) begin
          mem[6'(s_addr + 32'(s_cnt))] <= wdata;
          s_cnt <= s_cnt + 1'b1;
          if (s_cnt + 1'b1 == s_len) s_st <= S_WCHK;
        end
        S_WCHK: s_st <= S_IDLE;
        S_R: if (rready) begin
          rdata  <= mem[6'(s_addr + 32'(s_cnt))];
          rvalid <= 1'b1;
          rlast  <= (s_cnt + 1'b1 == s_len);
          s_cnt  <= s_cnt + 1'b1;
          if (s_cnt + 1'b1 == s_len) s_st <= S_IDLE;
        end
        default: s_st <= S_IDLE;
      endcase
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic kind;
    int   w;
    int   r;
    int   lat;
  } ev_t;

  ev_t         ev_q[$];
  logic [31:0] w_q[$];

  task automatic expect_ev(input logic k, input int w,
                           input int r, input int lat);
    ev_t e;
    e.kind = k;
    e.w = w;
    e.r = r;
    e.lat = lat;
    ev_q.push_back(e);
  endtask

  int cyc = 0;
  int hs_cyc = 0;
  int wc = 0;
  int rc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((awvalid && awready) || (arvalid && arready))
      hs_cyc <= cyc;
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      wc = 0;
      rc = 0;
    end else begin
      if (wready) begin
        wc++;
        if (w_q.size() == 0)
          check("unexpected_wbeat", 1, 0);
        else
          check("wdata", wdata, w_q.pop_front());
      end else if (wdata != '0) begin
        check("wdata_idle_zero", wdata, 0);
      end
      if (rready) rc++;
      if (done || err) begin
        if (ev_q.size() == 0) begin
          check("unexpected_done_err",
                {30'b0, done, err}, 0);
        end else begin
          e = ev_q.pop_front();
          check("err_pulse", err, e.kind);
          check("done_pulse", done, !e.kind);
          check("wready_cycles", wc, e.w);
          check("rready_cycles", rc, e.r);
          if (e.lat >= 0)
            check("hs_to_done", cyc - hs_cyc, e.lat);
        end
        wc = 0;
        rc = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    buf_we = 1'b1;
    buf_idx = IW'(idx);
    buf_wdata = d;
    tick();
    buf_we = 1'b0;
  endtask

  task automatic request(input logic wr,
                         input logic [31:0] addr,
                         input logic [7:0] len);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr = addr;
    req_len = len;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(done || err) && n < 100) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, done || err, 1);
  endtask

  task automatic check_buf(input int idx,
                           input logic [31:0] exp,
                           input string name);
    buf_idx = IW'(idx);
    tick();
    check(name, buf_rdata, exp);
  endtask

  task automatic check_idle_outs(input string name);
    check(name, 32'(|{awvalid, arvalid, wready, rready,
                      done, err, busy, wdata, awaddr,
                      awlen, araddr, arlen}), 0);
  endtask

  logic [31:0] v4 [4];

  initial begin
    int seen;
    int n;
    v4[0] = 32'h11;
    v4[1] = 32'h22;
    v4[2] = 32'h33;
    v4[3] = 32'h44;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_req_ready", req_ready, 1);
    check_idle_outs("reset_outputs");

    // Write 4 words to 0x40.
    for (int i = 0; i < 4; i++) load(i, v4[i]);
    for (int i = 0; i < 4; i++) w_q.push_back(v4[i]);
    expect_ev(1'b0, 4, 0, 6);
    request(1'b1, 32'h40, 8'd4);
    wait_done("wr4");
    tick();
    for (int i = 0; i < 4; i++)
      check("mem_wr4", mem[16 + i], v4[i]);

    // Read them back into a cleared buffer.
    for (int i = 0; i < 4; i++) load(i, 32'h0);
    expect_ev(1'b0, 0, 4, 6);
    request(1'b0, 32'h40, 8'd4);
    wait_done("rd4");
    tick();
    for (int i = 0; i < 4; i++)
      check_buf(i, v4[i], "buf_rd4");

    // Write 8 to 0x0, read 8 requested in the done cycle.
    for (int i = 0; i < 8; i++) load(i, 32'hA0 + i);
    for (int i = 0; i < 8; i++) w_q.push_back(32'hA0 + i);
    expect_ev(1'b0, 8, 0, 10);
    expect_ev(1'b0, 0, 8, 10);
    request(1'b1, 32'h0, 8'd8);
    wait_done("wr8");
    request(1'b0, 32'h0, 8'd8);
    wait_done("rd8");
    tick();
    for (int i = 0; i < 8; i++)
      check("mem_wr8", mem[i], 32'hA0 + i);
    for (int i = 0; i < 8; i++)
      check_buf(i, 32'hA0 + i, "buf_rd8");

    // Zero length: done next cycle, no bus activity.
    expect_ev(1'b0, 0, 0, -1);
    request(1'b1, 32'h100, 8'd0);
    check("len0_done", done, 1);
    check("len0_awvalid", awvalid, 0);
    check("len0_busy", busy, 0);
    tick();

    // Oversize: err pulse only.
    expect_ev(1'b1, 0, 0, -1);
    request(1'b0, 32'h100, 8'd9);
    check("len9_err", err, 1);
    check("len9_done", done, 0);
    check("len9_bus", 32'(awvalid | arvalid), 0);
    check("len9_busy", busy, 0);
    tick();
    check("len9_err_pulse", err, 0);

    // Host buffer write during a read is ignored.
    expect_ev(1'b0, 0, 4, 6);
    request(1'b0, 32'h40, 8'd4);
    buf_idx = 3'd2;
    buf_wdata = 32'hDEAD;
    buf_we = 1'b1;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    buf_we = 1'b0;
    wait_done("rd_we");
    tick();
    check_buf(2, 32'h33, "buf_we_ignored");

    // Reset after two of four write beats.
    for (int i = 0; i < 4; i++) load(i, 32'h50 + i);
    for (int i = 0; i < 4; i++) w_q.push_back(32'h50 + i);
    expect_ev(1'b0, 4, 0, 6);
    request(1'b1, 32'h80, 8'd4);
    seen = 0;
    n = 0;
    while (seen < 2 && n < 50) begin
      if (wready) seen++;
      if (seen < 2) tick();
      n++;
    end
    check("two_beats_seen", seen, 2);
    rst = 1'b1;
    tick();
    check_idle_outs("midburst_reset_outputs");
    check("midburst_req_ready", req_ready, 1);
    w_q.delete();
    ev_q.delete();
    rst = 1'b0;
    tick();

    // Read 2 from 0x40 after the aborted burst.
    load(0, 32'h0);
    load(1, 32'h0);
    expect_ev(1'b0, 0, 2, 4);
    request(1'b0, 32'h40, 8'd2);
    wait_done("rd2");
    tick();
    check_buf(0, 32'h11, "buf_rd2");
    check_buf(1, 32'h22, "buf_rd2");

    repeat (3) tick();
    check("queues_empty",
          32'(ev_q.size() + w_q.size()), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
